// File: rtl/ldpc_dec_ctrl_mc.sv
// LDPC decoder main control FSM.
// Sequences the load / vnode / cnode phases of one codeword at a time and
// drives the address generator and the engine framing. Block size, data
// size, iteration limit, early-stop mode and tag are latched when a codeword
// is accepted, so mid-codeword input changes have no effect.
module ldpc_dec_ctrl_mc #(
    parameter int pADDR_W      = 8,
    parameter int pITER_W      = 8,
    parameter int pTAG_W       = 4,
    parameter int pSTOP_CNT    = 1,
    parameter int pUSE_MN_MODE = 0
) (
    input  logic               iclk,
    input  logic               ireset_n,
    input  logic               iclkena,
    input  logic [pITER_W-1:0] iNiter,
    input  logic               ifmode,
    input  logic [pADDR_W:0]   iblock_size,
    input  logic [pADDR_W:0]   idata_size,
    input  logic               ibuf_full,
    input  logic [pTAG_W-1:0]  ibuf_tag,
    output logic               obuf_rempty,
    input  logic               iobuf_empty,
    output logic               oload_mode,
    output logic               oc_nv_mode,
    output logic               oaddr_clear,
    output logic               oaddr_enable,
    input  logic               ivnode_busy,
    output logic               ovnode_sop,
    output logic               ovnode_val,
    output logic               ovnode_eop,
    input  logic               icnode_busy,
    input  logic               icnode_decfail,
    output logic               ocnode_sop,
    output logic               ocnode_val,
    output logic               ocnode_eop,
    output logic               olast_iter,
    output logic               odone,
    output logic [pITER_W-1:0] oiter_used,
    output logic               odecfail,
    output logic [pTAG_W-1:0]  otag
);

    localparam int PC_W = 4;  // pass counter covers pSTOP_CNT up to 15

    typedef enum logic [2:0] {
        S_RESET      = 3'd0,
        S_WAIT       = 3'd1,
        S_VSTEP      = 3'd2,
        S_WAIT_VDONE = 3'd3,
        S_HSTEP      = 3'd4,
        S_WAIT_HDONE = 3'd5,
        S_WAIT_O     = 3'd6,
        S_DONE       = 3'd7
    } state_t;

    state_t              state_q, state_d;

    // latched per-codeword configuration
    logic [pADDR_W:0]    blk_q, dat_q;
    logic [pTAG_W-1:0]   tag_q;
    logic                fmode_q;

    // iteration bookkeeping
    logic [pITER_W-1:0]  iter_cnt_q, iter_used_q;
    logic [PC_W-1:0]     pass_cnt_q;
    logic                decfail_q;
    logic [pADDR_W-1:0]  cnt_q;

    // registered outputs
    logic                load_mode_q;
    logic                buf_rempty_q, c_nv_mode_q, addr_clear_q, addr_enable_q;
    logic                vsop_q, vval_q, veop_q, csop_q, cval_q, ceop_q;
    logic                done_q, odecfail_q;
    logic [pITER_W-1:0]  oiter_used_q;
    logic [pTAG_W-1:0]   otag_q;

    // termination terms
    logic                iter_last, fast_stop, do_last, iter_last_dec;
    logic [pITER_W-1:0]  iter_dec;
    logic [pADDR_W:0]    n_sel, n_m1;
    logic                step_zero, step_done;

    assign iter_last     = (iter_cnt_q == '0);
    assign fast_stop     = fmode_q && (pass_cnt_q == PC_W'(pSTOP_CNT));
    assign do_last       = iter_last || fast_stop;
    // value iter_cnt takes once the current cnode phase is retired
    assign iter_dec      = (iter_cnt_q != '0) ? iter_cnt_q - pITER_W'(1) : '0;
    assign iter_last_dec = (iter_dec == '0);

    // final vnode phase may be shortened to the data part of the block
    assign n_sel     = (state_q == S_VSTEP && do_last && pUSE_MN_MODE == 0) ? dat_q : blk_q;
    assign n_m1      = n_sel - (pADDR_W+1)'(1);
    assign step_zero = (cnt_q == '0);
    assign step_done = ({1'b0, cnt_q} == n_m1);

    // next-state decode; unknown encodings fall back to RESET
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:      state_d = S_WAIT;
            S_WAIT:       if (ibuf_full) state_d = S_VSTEP;
            S_VSTEP:      if (step_done) state_d = S_WAIT_VDONE;
            S_WAIT_VDONE: if (!ivnode_busy) state_d = do_last ? S_DONE : S_HSTEP;
            S_HSTEP:      if (step_done) state_d = S_WAIT_HDONE;
            S_WAIT_HDONE: if (!icnode_busy)
                              state_d = (iter_last_dec && !iobuf_empty) ? S_WAIT_O : S_VSTEP;
            S_WAIT_O:     if (iobuf_empty) state_d = S_VSTEP;
            S_DONE:       state_d = S_WAIT;
            default:      state_d = S_RESET;
        endcase
    end

    // FSM state, bookkeeping and all registered outputs; everything holds when iclkena is low
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state_q       <= S_RESET;
            blk_q         <= '0;
            dat_q         <= '0;
            tag_q         <= '0;
            fmode_q       <= 1'b0;
            iter_cnt_q    <= '0;
            iter_used_q   <= '0;
            pass_cnt_q    <= '0;
            decfail_q     <= 1'b0;
            cnt_q         <= '0;
            load_mode_q   <= 1'b0;
            buf_rempty_q  <= 1'b0;
            c_nv_mode_q   <= 1'b0;
            addr_clear_q  <= 1'b1;
            addr_enable_q <= 1'b0;
            vsop_q        <= 1'b0;
            vval_q        <= 1'b0;
            veop_q        <= 1'b0;
            csop_q        <= 1'b0;
            cval_q        <= 1'b0;
            ceop_q        <= 1'b0;
            done_q        <= 1'b0;
            odecfail_q    <= 1'b0;
            oiter_used_q  <= '0;
            otag_q        <= '0;
        end else if (iclkena) begin
            state_q <= state_d;

            // step counter runs only inside a step phase and rewinds on its last cycle
            if (state_q == S_VSTEP || state_q == S_HSTEP)
                cnt_q <= step_done ? '0 : cnt_q + pADDR_W'(1);
            else
                cnt_q <= '0;

            case (state_q)
                S_WAIT: if (ibuf_full) begin
                    blk_q       <= iblock_size;
                    dat_q       <= idata_size;
                    tag_q       <= ibuf_tag;
                    fmode_q     <= ifmode;
                    iter_cnt_q  <= (iNiter == '0) ? pITER_W'(1) : iNiter;
                    iter_used_q <= '0;
                    pass_cnt_q  <= '0;
                    load_mode_q <= 1'b1;
                end
                S_WAIT_VDONE: if (!ivnode_busy) begin
                    iter_used_q <= iter_used_q + pITER_W'(1);
                    load_mode_q <= 1'b0;
                end
                S_WAIT_HDONE: if (!icnode_busy) begin
                    if (icnode_decfail)
                        pass_cnt_q <= '0;
                    else if (pass_cnt_q < PC_W'(pSTOP_CNT))
                        pass_cnt_q <= pass_cnt_q + PC_W'(1);
                    decfail_q  <= icnode_decfail;
                    iter_cnt_q <= iter_dec;
                end
                default: ;
            endcase

            // addr_gen / buffer controls follow the next state so they line up with it
            buf_rempty_q  <= (state_d == S_DONE);
            done_q        <= (state_d == S_DONE);
            c_nv_mode_q   <= (state_d == S_HSTEP) || (state_d == S_WAIT_HDONE);
            addr_clear_q  <= (state_d == S_WAIT) || (state_d == S_WAIT_VDONE) ||
                             (state_d == S_WAIT_HDONE);
            addr_enable_q <= (state_d == S_VSTEP) || (state_d == S_HSTEP);

            // result fields are captured on the only path into DONE
            if (state_q == S_WAIT_VDONE && state_d == S_DONE) begin
                oiter_used_q <= iter_used_q + pITER_W'(1);
                odecfail_q   <= decfail_q;
                otag_q       <= tag_q;
            end

            // engine framing trails the step cycle by one
            vval_q <= (state_q == S_VSTEP);
            vsop_q <= (state_q == S_VSTEP) && step_zero;
            veop_q <= (state_q == S_VSTEP) && step_done;
            cval_q <= (state_q == S_HSTEP);
            csop_q <= (state_q == S_HSTEP) && step_zero;
            ceop_q <= (state_q == S_HSTEP) && step_done;
        end
    end

    assign obuf_rempty  = buf_rempty_q;
    assign oload_mode   = load_mode_q;
    assign oc_nv_mode   = c_nv_mode_q;
    assign oaddr_clear  = addr_clear_q;
    assign oaddr_enable = addr_enable_q;
    assign ovnode_sop   = vsop_q;
    assign ovnode_val   = vval_q;
    assign ovnode_eop   = veop_q;
    assign ocnode_sop   = csop_q;
    assign ocnode_val   = cval_q;
    assign ocnode_eop   = ceop_q;
    assign olast_iter   = ((state_q == S_VSTEP) || (state_q == S_WAIT_VDONE)) && do_last;
    assign odone        = done_q;
    assign oiter_used   = oiter_used_q;
    assign odecfail     = odecfail_q;
    assign otag         = otag_q;

endmodule

// File: tb/tb_ldpc_dec_ctrl_mc.sv
// Scoreboard bench for ldpc_dec_ctrl_mc: stimulus pushes expected phase
// lengths and per-codeword results, a negedge monitor pops and compares.
module tb_ldpc_dec_ctrl_mc;

    logic       clk = 1'b0;
    logic       ireset_n;
    logic       iclkena;
    logic [7:0] iNiter;
    logic       ifmode;
    logic [8:0] iblock_size, idata_size;
    logic       ibuf_full;
    logic [3:0] ibuf_tag;
    logic       obuf_rempty;
    logic       iobuf_empty;
    logic       oload_mode, oc_nv_mode, oaddr_clear, oaddr_enable;
    logic       ivnode_busy;
    logic       ovnode_sop, ovnode_val, ovnode_eop;
    logic       icnode_busy, icnode_decfail;
    logic       ocnode_sop, ocnode_val, ocnode_eop;
    logic       olast_iter, odone;
    logic [7:0] oiter_used;
    logic       odecfail;
    logic [3:0] otag;

    always #5 clk = ~clk;

    ldpc_dec_ctrl_mc #(
        .pADDR_W(8), .pITER_W(8), .pTAG_W(4), .pSTOP_CNT(2), .pUSE_MN_MODE(0)
    ) dut (
        .iclk(clk), .ireset_n(ireset_n), .iclkena(iclkena),
        .iNiter(iNiter), .ifmode(ifmode),
        .iblock_size(iblock_size), .idata_size(idata_size),
        .ibuf_full(ibuf_full), .ibuf_tag(ibuf_tag), .obuf_rempty(obuf_rempty),
        .iobuf_empty(iobuf_empty), .oload_mode(oload_mode), .oc_nv_mode(oc_nv_mode),
        .oaddr_clear(oaddr_clear), .oaddr_enable(oaddr_enable),
        .ivnode_busy(ivnode_busy),
        .ovnode_sop(ovnode_sop), .ovnode_val(ovnode_val), .ovnode_eop(ovnode_eop),
        .icnode_busy(icnode_busy), .icnode_decfail(icnode_decfail),
        .ocnode_sop(ocnode_sop), .ocnode_val(ocnode_val), .ocnode_eop(ocnode_eop),
        .olast_iter(olast_iter), .odone(odone), .oiter_used(oiter_used),
        .odecfail(odecfail), .otag(otag)
    );

    typedef struct {
        int tag;
        int iter;
        int dec;
        int en;
        int nv;
    } exp_t;

    exp_t exp_done[$];
    int   exp_v[$];
    int   exp_c[$];
    int   dec_q[$];

    int n_chk = 0, n_pass = 0;
    int vtail = 0, ctail = 0;
    int vcnt = 0, ccnt = 0;
    int vlen = 0, clen = 0, en_cnt = 0, vidx = 0;
    int done_cnt = 0, c_eops = 0;
    bit prev_done = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
    endtask

    // push the expected phase lengths and result of one codeword
    task automatic expect_cw(input int tag, input int iter, input int dec, input int blk,
                             input int dat, input int nc, input int stall);
        exp_t e;
        int   len;
        e.tag = tag; e.iter = iter; e.dec = dec; e.nv = iter; e.en = 0;
        for (int i = 0; i < iter; i++) begin
            len = (i == iter - 1) ? dat : blk;
            if (i == 0) len += stall;
            exp_v.push_back(len);
            e.en += len;
        end
        for (int i = 0; i < nc; i++) begin
            exp_c.push_back(blk);
            e.en += blk;
        end
        exp_done.push_back(e);
    endtask

    // offer a codeword, wait for acceptance, then disturb the config inputs
    task automatic start_cw(input int tag, input int niter, input bit fm, input int blk, input int dat);
        bit ok = 1'b0;
        ibuf_tag = 4'(tag); iNiter = 8'(niter); ifmode = fm;
        iblock_size = 9'(blk); idata_size = 9'(dat);
        ibuf_full = 1'b1;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            if (oaddr_enable) ok = 1'b1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        ibuf_full = 1'b0;
        iblock_size = 9'd3; idata_size = 9'd2; iNiter = 8'd1; ifmode = ~fm;
    endtask

    task automatic wait_done();
        int start = done_cnt;
        bit ok = 1'b0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            @(negedge clk);
            if (done_cnt != start) ok = 1'b1;
        end
        if (!ok) chk("done_timeout", 0, 1);
    endtask

    // engine model: busy tails after eop, decfail per cnode phase on sop
    always @(negedge clk) begin
        if (!ireset_n) begin
            vcnt = 0; ccnt = 0;
            dec_q.delete();
        end else begin
            if (vcnt > 0) vcnt--;
            if (ccnt > 0) ccnt--;
            if (ovnode_eop) vcnt = vtail;
            if (ocnode_eop) ccnt = ctail;
            if (ocnode_sop) icnode_decfail = (dec_q.size() > 0) ? dec_q.pop_front() != 0 : 1'b0;
        end
        ivnode_busy = (vcnt > 0);
        icnode_busy = (ccnt > 0);
    end

    // monitor: phase lengths, framing side-signals and codeword results
    always @(negedge clk) begin
        int   e, nv_e;
        exp_t d;
        if (!ireset_n) begin
            exp_v.delete(); exp_c.delete(); exp_done.delete();
            vlen = 0; clen = 0; en_cnt = 0; vidx = 0; prev_done = 1'b0;
        end else begin
            if (prev_done) chk("done_pulse_width", {odone, obuf_rempty}, 0);
            prev_done = odone;
            if (oaddr_enable) en_cnt++;
            if (ovnode_val) begin
                vlen = ovnode_sop ? 1 : vlen + 1;
                if (ovnode_eop) begin
                    if (exp_v.size() == 0) chk("vphase_unexpected", 1, 0);
                    else begin
                        e = exp_v.pop_front();
                        chk("vphase_len", vlen, e);
                    end
                    nv_e = (exp_done.size() > 0) ? exp_done[0].nv : -1;
                    chk("load_mode", oload_mode, vidx == 0);
                    chk("last_iter", olast_iter, vidx == nv_e - 1);
                    vidx++;
                end
            end
            if (ocnode_val) begin
                clen = ocnode_sop ? 1 : clen + 1;
                if (ocnode_eop) begin
                    if (exp_c.size() == 0) chk("cphase_unexpected", 1, 0);
                    else begin
                        e = exp_c.pop_front();
                        chk("cphase_len", clen, e);
                    end
                    c_eops++;
                end
            end
            if (odone) begin
                if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    d = exp_done.pop_front();
                    chk("otag", otag, d.tag);
                    chk("oiter_used", oiter_used, d.iter);
                    chk("odecfail", odecfail, d.dec);
                    chk("enable_cycles", en_cnt, d.en);
                    chk("rempty_with_done", obuf_rempty, 1);
                    chk("vphase_count", vidx, d.nv);
                end
                en_cnt = 0; vidx = 0;
                done_cnt++;
            end
        end
    end

    initial begin
        int  base;
        bit  ok;
        ireset_n = 1'b1; iclkena = 1'b1; iNiter = 8'd1; ifmode = 1'b0;
        iblock_size = 9'd8; idata_size = 9'd4; ibuf_full = 1'b0; ibuf_tag = 4'd0;
        iobuf_empty = 1'b1; ivnode_busy = 1'b0; icnode_busy = 1'b0; icnode_decfail = 1'b0;
        #1 ireset_n = 1'b0;
        repeat (3) @(negedge clk);
        // reset state
        chk("rst_addr_clear", oaddr_clear, 1);
        chk("rst_ctrl", {obuf_rempty, oload_mode, oc_nv_mode, oaddr_enable, olast_iter, odone}, 0);
        chk("rst_framing", {ovnode_sop, ovnode_val, ovnode_eop, ocnode_sop, ocnode_val, ocnode_eop}, 0);
        chk("rst_results", {oiter_used, odecfail, otag}, 0);
        ireset_n = 1'b1;
        @(negedge clk);
        chk("wait_addr_clear", oaddr_clear, 1);

        // 1: fixed iterations, early stop disabled even though passes occur
        dec_q = '{0, 0, 1};
        expect_cw(1, 4, 1, 8, 4, 3, 0);
        start_cw(1, 3, 1'b0, 8, 4);
        wait_done();

        // 2: early stop after two consecutive passes, with engine busy tails
        vtail = 2; ctail = 1;
        dec_q = '{1, 0, 0};
        expect_cw(2, 4, 0, 5, 3, 3, 0);
        start_cw(2, 10, 1'b1, 5, 3);
        wait_done();

        // 3: single-step phases
        vtail = 1; ctail = 0;
        dec_q = '{1, 0};
        expect_cw(3, 3, 0, 1, 1, 2, 0);
        start_cw(3, 2, 1'b0, 1, 1);
        wait_done();

        // 4: output buffer not ready at the last cnode completion
        vtail = 0; ctail = 0;
        iobuf_empty = 1'b0;
        dec_q = '{1, 1};
        base = c_eops;
        expect_cw(4, 3, 1, 4, 2, 2, 0);
        start_cw(4, 2, 1'b0, 4, 2);
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (c_eops == base + 2) ok = 1'b1;
        end
        if (!ok) chk("wait_o_timeout", 0, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("wait_o_enable", oaddr_enable, 0);
            chk("wait_o_vval", ovnode_val, 0);
        end
        iobuf_empty = 1'b1;
        @(negedge clk);
        chk("wait_o_resume", oaddr_enable, 1);
        wait_done();

        // 5: zero iteration limit acts as one
        dec_q = '{1};
        expect_cw(6, 2, 1, 6, 3, 1, 0);
        start_cw(6, 0, 1'b0, 6, 3);
        wait_done();

        // 6: async reset mid cnode phase, then a stalled codeword
        dec_q = '{0, 0, 0};
        expect_cw(9, 4, 0, 8, 4, 3, 0);
        start_cw(9, 3, 1'b0, 8, 4);
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (ocnode_sop) ok = 1'b1;
        end
        if (!ok) chk("hstep_timeout", 0, 1);
        repeat (2) @(negedge clk);
        chk("in_hstep", {oc_nv_mode, oaddr_enable}, 3);
        #2 ireset_n = 1'b0;
        #1;
        chk("async_rst_enable", oaddr_enable, 0);
        chk("async_rst_cnv", oc_nv_mode, 0);
        chk("async_rst_cval", ocnode_val, 0);
        chk("async_rst_clear", oaddr_clear, 1);
        repeat (2) @(negedge clk);
        ireset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_wait", {oaddr_clear, oaddr_enable}, 2);

        dec_q = '{0};
        expect_cw(5, 2, 0, 8, 4, 1, 3);
        start_cw(5, 1, 1'b0, 8, 4);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            if (ovnode_sop) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) chk("vstep_timeout", 0, 1);
        repeat (2) @(negedge clk);
        iclkena = 1'b0;
        repeat (3) @(negedge clk);
        iclkena = 1'b1;
        wait_done();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ldpc_dec_ctrl_mc.md
Name: ldpc_dec_ctrl_mc

Overview:
Next-generation main FSM for the LDPC decoder, driving the address generator and the vnode/cnode engines.
- Block and data sizes are latched at run time per codeword (max set by parameter), so one decoder instance serves several code rates.
- Early stop needs a configurable number of consecutive syndrome passes.
- A per-codeword tag is carried through, together with the used-iteration count and the decode-fail status.
- Sits between the input LLR buffer, the addr_gen, the vnode/cnode engines and the output buffer.

Parameters:
pADDR_W, 8, step counter width; max block size is 2**pADDR_W.
pITER_W, 8, iteration counter width.
pTAG_W, 4, codeword tag width.
pSTOP_CNT, 1, consecutive passing cnode phases required for early stop (1..15).
pUSE_MN_MODE, 0, 1 = last vnode phase uses block size; 0 = last vnode phase uses data size.

Ports:
iclk  in  1  clock
ireset_n  in  1  asynchronous active-low reset
iclkena  in  1  clock enable; all state holds when low
iNiter  in  pITER_W  max iterations; 0 treated as 1
ifmode  in  1  early-stop enable
iblock_size  in  pADDR_W+1  steps per cnode/vnode phase (1..2**pADDR_W)
idata_size  in  pADDR_W+1  steps in final vnode phase (1..iblock_size)
ibuf_full  in  1  input buffer holds a codeword
ibuf_tag  in  pTAG_W  tag of the buffered codeword
obuf_rempty  out  1  release input buffer (1-cycle pulse)
iobuf_empty  in  1  output buffer can accept
oload_mode  out  1  first vnode phase reads channel LLRs
oc_nv_mode  out  1  1 = cnode phase addressing
oaddr_clear  out  1  addr_gen clear
oaddr_enable  out  1  addr_gen advance
ivnode_busy  in  1  vnode engine pipeline busy
ovnode_sop/ovnode_val/ovnode_eop  out  1 each  vnode framing
icnode_busy  in  1  cnode engine busy
icnode_decfail  in  1  syndrome fail; valid when icnode_busy falls
ocnode_sop/ocnode_val/ocnode_eop  out  1 each  cnode framing
olast_iter  out  1  current vnode phase is final (combinational from state)
odone  out  1  1-cycle pulse: codeword finished
oiter_used  out  pITER_W  iterations executed; valid with odone
odecfail  out  1  last syndrome failed; valid with odone
otag  out  pTAG_W  tag; valid with odone

Behaviour:
- Reset (async, ireset_n low):
  - state = RESET.
  - All outputs 0 except oaddr_clear = 1.
  - oiter_used, otag, odecfail = 0.
- States: RESET -> WAIT (unconditional).
- WAIT -> VSTEP on ibuf_full. In that cycle latch:
  - sizes, tag, iter_cnt = max(iNiter,1), iter_used = 0, pass_cnt = 0
  - oload_mode = 1
- VSTEP -> WAIT_VDONE when step.done.
- WAIT_VDONE, on !ivnode_busy:
  - iter_used++, oload_mode = 0.
  - -> DONE if do_last, else -> HSTEP.
- HSTEP -> WAIT_HDONE when step.done.
- WAIT_HDONE, on !icnode_busy:
  - Update pass_cnt: if icnode_decfail, pass_cnt = 0; else pass_cnt++, saturating at pSTOP_CNT.
  - Latch decfail = icnode_decfail.
  - iter_cnt decrements.
  - -> WAIT_O if (iter_last & !iobuf_empty), else -> VSTEP.
- WAIT_O -> VSTEP when iobuf_empty.
- DONE -> WAIT. In DONE, odone pulses with oiter_used/odecfail/otag.
- Termination terms:
  - iter_last = (iter_cnt == 0) after decrement.
  - fast_stop = ifmode & (pass_cnt == pSTOP_CNT).
  - do_last = iter_last | fast_stop.
- Step counter:
  - Loaded to 0 in WAIT/WAIT_VDONE/WAIT_HDONE.
  - zero = 1 on first step cycle.
  - done asserted on the cycle cnt == N-1, where N = idata_size if (VSTEP & do_last & !pUSE_MN_MODE), else iblock_size.
  - N = 1 gives zero and done in the same cycle.
  - Each step phase lasts exactly N cycles.
- Registered from next_state, 1 cycle latency:
  - obuf_rempty = (next == DONE).
  - oc_nv_mode = next in {HSTEP, WAIT_HDONE}.
  - oaddr_clear = next in {WAIT, WAIT_VDONE, WAIT_HDONE}.
  - oaddr_enable = next in {VSTEP, HSTEP}.
- Engine framing, registered from state, 1 cycle after step cycle:
  - ovnode_val = (state == VSTEP); ovnode_sop = val & zero; ovnode_eop = val & done.
  - ocnode_sop/val/eop: same from HSTEP.
- Sizes, iNiter and ifmode changes mid-codeword are ignored (latched copies used).
- Illegal state encoding -> RESET.

Test Plan:
1. iNiter=3, ifmode=0, block=8, data=4, pUSE_MN_MODE=0:
   - Required: 4 vnode phases (8,8,8,4 val cycles) and 3 cnode phases of 8.
   - Required: odone with oiter_used=4, obuf_rempty pulse 1 cycle before WAIT.
2. ifmode=1, pSTOP_CNT=2, decfail sequence 1,0,0:
   - Required: stop after third cnode phase; final vnode phase uses data size; oiter_used=4, odecfail=0.
3. block=1, data=1:
   - Required: sop, val and eop coincide on every phase; no extra enable cycles.
4. iobuf_empty=0 at last cnode completion:
   - Required: FSM holds in WAIT_O, oaddr_enable=0; resumes VSTEP 1 cycle after iobuf_empty=1.
5. iNiter=0:
   - Required: behaves as iNiter=1 (2 vnode phases, 1 cnode phase).
6. ireset_n low mid-HSTEP:
   - Required: outputs clear immediately (async).
   - Required: after release, RESET -> WAIT; a new codeword tag=5 completes with otag=5.
   - iclkena=0 for 3 cycles mid-VSTEP: phase is stretched by exactly 3 cycles.
